// File: rtl/axi_burst_read_responder_if.sv
// Bundle of the AR/R channel and backing-memory signals of the line-fill responder.
// Signal names are seen from the responder side: i_* are driven into it, o_* come out of it.
interface axi_burst_read_responder_if #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH    = 512
);
    logic                      i_arvalid;
    logic                      o_arready;
    logic [AXI_ADDR_WIDTH-1:0] i_araddr;
    logic [7:0]                i_arlen;
    logic                      o_mem_req;
    logic [AXI_ADDR_WIDTH-1:0] o_mem_addr;
    logic                      i_mem_ack;
    logic [BLOCK_WIDTH-1:0]    i_mem_block;
    logic                      o_rvalid;
    logic                      i_rready;
    logic [AXI_DATA_WIDTH-1:0] o_rdata;
    logic [1:0]                o_rresp;
    logic                      o_rlast;

    modport slave (
        input  i_arvalid, i_araddr, i_arlen, i_mem_ack, i_mem_block, i_rready,
        output o_arready, o_mem_req, o_mem_addr, o_rvalid, o_rdata, o_rresp, o_rlast
    );

    modport master (
        output i_arvalid, i_araddr, i_arlen, i_mem_ack, i_mem_block, i_rready,
        input  o_arready, o_mem_req, o_mem_addr, o_rvalid, o_rdata, o_rresp, o_rlast
    );
endinterface

// File: rtl/axi_burst_read_responder.sv
// Memory-side AXI4 read-burst responder: fetches a whole cache line in one backing access
// and streams it out LSB word first; any length other than one full line gets SLVERR beats.
module axi_burst_read_responder #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH    = 512
) (
    input logic                       clk,
    input logic                       arstn,
    axi_burst_read_responder_if.slave bus
);
    localparam int unsigned BEATS    = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int unsigned OFFS     = $clog2(BLOCK_WIDTH / 8);
    localparam logic [7:0]  LastBeat = 8'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StSend, StErr} state_e;

    state_e                    state_q;
    logic [7:0]                len_q;
    logic [7:0]                beat_cnt_q;
    logic [BLOCK_WIDTH-1:0]    buf_q;
    logic                      mem_req_q;
    logic [AXI_ADDR_WIDTH-1:0] mem_addr_q;
    logic                      rvalid_q;
    logic                      rlast_q;
    logic [1:0]                rresp_q;

    logic ar_hs;
    logic r_hs;
    logic unused_addr_bits;

    assign ar_hs            = bus.i_arvalid && (state_q == StIdle);
    assign r_hs             = rvalid_q && bus.i_rready;
    assign unused_addr_bits = ^bus.i_araddr[OFFS-1:0];

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= StIdle;
            len_q      <= '0;
            beat_cnt_q <= '0;
            buf_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ar_hs) begin
                        len_q      <= bus.i_arlen;
                        mem_addr_q <= {bus.i_araddr[AXI_ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
                        beat_cnt_q <= '0;
                        if (bus.i_arlen == LastBeat) begin
                            state_q   <= StFetch;
                            mem_req_q <= 1'b1;
                        end else begin
                            // Error beats carry zero data, so the buffer is cleared here.
                            state_q  <= StErr;
                            buf_q    <= '0;
                            rvalid_q <= 1'b1;
                            rresp_q  <= 2'b10;
                            rlast_q  <= (bus.i_arlen == 8'd0);
                        end
                    end
                end
                StFetch: begin
                    if (bus.i_mem_ack) begin
                        state_q    <= StSend;
                        buf_q      <= bus.i_mem_block;
                        beat_cnt_q <= '0;
                        mem_req_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rresp_q    <= 2'b00;
                        rlast_q    <= (len_q == 8'd0);
                    end
                end
                StSend, StErr: begin
                    if (r_hs) begin
                        buf_q <= buf_q >> AXI_DATA_WIDTH;
                        if (beat_cnt_q == len_q) begin
                            state_q  <= StIdle;
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            rresp_q  <= 2'b00;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                            rlast_q    <= ((beat_cnt_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_arready  = (state_q == StIdle);
    assign bus.o_mem_req  = mem_req_q;
    assign bus.o_mem_addr = mem_addr_q;
    assign bus.o_rvalid   = rvalid_q;
    assign bus.o_rdata    = buf_q[AXI_DATA_WIDTH-1:0];
    assign bus.o_rresp    = rresp_q;
    assign bus.o_rlast    = rlast_q;
endmodule

// File: tb/tb_axi_burst_read_responder.sv
// Directed bench for axi_burst_read_responder: a table of bursts run through one loop,
// plus hand-written reset-abort and back-to-back sequences.
module tb_axi_burst_read_responder;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned BW    = 512;
    localparam int unsigned BEATS = BW / DW;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    axi_burst_read_responder_if #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .BLOCK_WIDTH   (BW)
    ) bus ();

    axi_burst_read_responder #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .BLOCK_WIDTH   (BW)
    ) dut (
        .clk  (clk),
        .arstn(arstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        is_err;
        logic [31:0] exp_mem_addr;
        logic [31:0] base;
        int          ack_delay;
        logic [3:0]  rdy_pat;  // rready for cycle c of the burst is rdy_pat[c % 4]
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] mk_block(input logic [31:0] base);
        logic [BW-1:0] blk;
        blk = '0;
        for (int i = 0; i < int'(BEATS); i++) blk[i*DW +: DW] = base + 32'(i);
        return blk;
    endfunction

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len);
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = addr;
        bus.i_arlen   = len;
        chk("arready_idle", 64'(bus.o_arready), 64'd1);
        step();
        bus.i_arvalid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] base, input int delay);
        chk("mem_req_next", 64'(bus.o_mem_req), 64'd1);
        chk("mem_addr", 64'(bus.o_mem_addr), 64'(exp_addr));
        chk("rvalid_in_fetch", 64'(bus.o_rvalid), 64'd0);
        for (int i = 0; i < delay; i++) begin
            step();
            chk("mem_req_hold", 64'(bus.o_mem_req), 64'd1);
            chk("mem_addr_hold", 64'(bus.o_mem_addr), 64'(exp_addr));
        end
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_block = mk_block(base);
        step();
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_block = '0;
        chk("mem_req_drop", 64'(bus.o_mem_req), 64'd0);
        chk("rvalid_after_ack", 64'(bus.o_rvalid), 64'd1);
    endtask

    task automatic recv(input int n, input logic [31:0] base, input logic is_err,
                        input logic [3:0] pat);
        int b;
        int cyc;
        logic rdy;
        b   = 0;
        cyc = 0;
        while (b < n && cyc < 4 * n + 16) begin
            rdy = pat[cyc % 4];
            bus.i_rready = rdy;
            if (bus.o_rvalid !== 1'b1) begin
                chk("rvalid_held", 64'(bus.o_rvalid), 64'd1);
                break;
            end
            chk("rdata", 64'(bus.o_rdata), is_err ? 64'd0 : 64'(base + 32'(b)));
            chk("rresp", 64'(bus.o_rresp), is_err ? 64'd2 : 64'd0);
            chk("rlast", 64'(bus.o_rlast), 64'(b == n - 1));
            chk("arready_busy", 64'(bus.o_arready), 64'd0);
            if (is_err) chk("no_mem_req", 64'(bus.o_mem_req), 64'd0);
            step();
            if (rdy) b++;
            cyc++;
        end
        bus.i_rready = 1'b0;
        chk("burst_beats", 64'(b), 64'(n));
        if (pat == 4'hF) chk("back_to_back_cycles", 64'(cyc), 64'(n));
        chk("rvalid_done", 64'(bus.o_rvalid), 64'd0);
        chk("arready_after", 64'(bus.o_arready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        send_ar(v.addr, v.len);
        if (!v.is_err) fetch(v.exp_mem_addr, v.base, v.ack_delay);
        else chk("err_no_mem_req", 64'(bus.o_mem_req), 64'd0);
        recv(int'(v.len) + 1, v.base, v.is_err, v.rdy_pat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_1234, 8'd15, 1'b0, 32'h0000_1200, 32'hA000_0000, 3, 4'b1111};
        vecs[1] = '{32'h0000_1234, 8'd15, 1'b0, 32'h0000_1200, 32'hA000_0000, 3, 4'b1001};
        vecs[2] = '{32'h0000_0040, 8'd3,  1'b1, 32'h0000_0000, 32'h0000_0000, 0, 4'b1111};
        vecs[3] = '{32'hFFFF_FFC7, 8'd15, 1'b0, 32'hFFFF_FFC0, 32'h5000_0000, 0, 4'b1111};
        vecs[4] = '{32'h0000_0100, 8'd0,  1'b1, 32'h0000_0000, 32'h0000_0000, 0, 4'b0110};
        vecs[5] = '{32'h0000_0200, 8'd16, 1'b1, 32'h0000_0000, 32'h0000_0000, 0, 4'b1111};

        bus.i_arvalid   = 1'b0;
        bus.i_araddr    = '0;
        bus.i_arlen     = '0;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_block = '0;
        bus.i_rready    = 1'b0;

        #1;
        chk("reset_arready", 64'(bus.o_arready), 64'd1);
        chk("reset_rvalid", 64'(bus.o_rvalid), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        step();
        chk("idle_arready", 64'(bus.o_arready), 64'd1);
        chk("idle_rvalid", 64'(bus.o_rvalid), 64'd0);
        chk("idle_mem_req", 64'(bus.o_mem_req), 64'd0);
        chk("idle_rlast", 64'(bus.o_rlast), 64'd0);
        chk("idle_rresp", 64'(bus.o_rresp), 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in the middle of a burst, after beats 0..5 were accepted.
        send_ar(32'h0000_2000, 8'd15);
        fetch(32'h0000_2000, 32'hB000_0000, 1);
        bus.i_rready = 1'b1;
        repeat (6) step();
        chk("pre_reset_rdata", 64'(bus.o_rdata), 64'hB000_0006);
        arstn = 1'b0;
        #1;
        bus.i_rready = 1'b0;
        chk("abort_rvalid", 64'(bus.o_rvalid), 64'd0);
        chk("abort_rlast", 64'(bus.o_rlast), 64'd0);
        chk("abort_rdata", 64'(bus.o_rdata), 64'd0);
        chk("abort_arready", 64'(bus.o_arready), 64'd1);
        @(negedge clk);
        arstn = 1'b1;
        step();
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_block = mk_block(32'hDEAD_0000);
        step();
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_block = '0;
        chk("idle_ack_rvalid", 64'(bus.o_rvalid), 64'd0);
        chk("idle_ack_arready", 64'(bus.o_arready), 64'd1);
        step();
        chk("idle_ack_rvalid2", 64'(bus.o_rvalid), 64'd0);
        send_ar(32'h0000_2000, 8'd15);
        fetch(32'h0000_2000, 32'hC000_0000, 2);
        recv(16, 32'hC000_0000, 1'b0, 4'b1111);

        // Reset while the backing read is pending; the late ack must be dropped.
        send_ar(32'h0000_3000, 8'd15);
        step();
        arstn = 1'b0;
        #1;
        chk("abort_fetch_mem_req", 64'(bus.o_mem_req), 64'd0);
        @(negedge clk);
        arstn = 1'b1;
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_block = mk_block(32'hDEAD_0000);
        step();
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_block = '0;
        chk("late_ack_rvalid", 64'(bus.o_rvalid), 64'd0);

        // Back-to-back: arvalid held high across two requests.
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = 32'h0000_3000;
        bus.i_arlen   = 8'd15;
        chk("b2b_arready1", 64'(bus.o_arready), 64'd1);
        step();
        bus.i_araddr = 32'h0000_4444;
        fetch(32'h0000_3000, 32'h1111_0000, 2);
        recv(16, 32'h1111_0000, 1'b0, 4'b1111);
        step();
        bus.i_arvalid = 1'b0;
        fetch(32'h0000_4440, 32'h2222_0000, 0);
        recv(16, 32'h2222_0000, 1'b0, 4'b1011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
